ysyx_22041412_ifu: RTL and testbench

YSYX_22041412_IFU -- requirements
Module: ysyx_22041412_ifu

---
 rtl/ysyx_22041412_pkg.sv | 20 ++
 rtl/ysyx_22041412_ifu.sv | 125 ++++++++++++
 tb/tb_ysyx_22041412_ifu.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041412_pkg.sv
// Shared definitions for the ysyx_22041412 fetch unit: FSM encoding,
// reset fetch address and the NOP instruction word.
package ysyx_22041412_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } ifu_state_t;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [63:0] PC_STEP          = 64'd4;

  // Fetch addresses are always word aligned; the low two bits are cleared.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'd3;
  endfunction

endpackage

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: issues one word fetch at a time, hands the word to
// decode with its PC, and handles redirects by dropping one stale response.
module ysyx_22041412_ifu
  import ysyx_22041412_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc
);

  ifu_state_t  r_state;
  ifu_state_t  w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] w_pc_nxt;
  logic        r_drop;
  logic        w_drop_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [63:0] r_out_pc;
  logic [63:0] w_out_pc_nxt;
  logic [63:0] w_redirect_pc;

  assign w_redirect_pc = align_pc(redirect_pc);

  // Handshake outputs are masked by rst so nothing is presented in the reset cycle.
  assign imem_req_valid = (r_state == S_REQ) && !rst;
  assign imem_addr      = r_pc;
  assign out_valid      = (r_state == S_VALID) && !rst;
  assign out_instr      = r_instr;
  assign out_pc         = r_out_pc;

  // Next-state logic; a redirect outranks every other event in each state.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_drop_nxt   = r_drop;
    w_instr_nxt  = r_instr;
    w_out_pc_nxt = r_out_pc;
    case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redirect_pc;
          if (imem_req_ready) begin
            // Old-address request was accepted, so its response must be dropped.
            w_state_nxt = S_WAIT;
            w_drop_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
          end
        end else if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redirect_pc;
          if (imem_rsp_valid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_drop_nxt  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_instr_nxt  = imem_rsp_data;
            w_out_pc_nxt = r_pc;
            w_pc_nxt     = r_pc + PC_STEP;
            w_state_nxt  = S_VALID;
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_VALID: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = S_REQ;
        end else if (out_ready) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_VALID;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
        w_drop_nxt  = 1'b0;
      end
    endcase
  end

  // State, PC, drop flag and decode output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_drop   <= 1'b0;
      r_instr  <= INSTR_NOP;
      r_out_pc <= 64'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_drop   <= w_drop_nxt;
      r_instr  <= w_instr_nxt;
      r_out_pc <= w_out_pc_nxt;
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// Directed self-checking bench for ysyx_22041412_ifu.
module tb_ysyx_22041412_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_22041412_ifu #(.RESET_PC(64'h0000_0000_8000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    out_ready = 1'b0;
    tick(); tick();
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'h13);
    chk("rst_out_pc", out_pc, 64'd0);

    // Scenario 1/2: basic fetch, then decode stalls for 5 cycles.
    rst = 1'b0; imem_req_ready = 1'b1; settle();
    chk("s1_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("s1_addr", imem_addr, 64'h0000_0000_8000_0000);
    tick();
    chk("s1_wait_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("s1_wait_out_valid", {63'd0, out_valid}, 64'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    tick();
    imem_rsp_valid = 1'b0;
    chk("s1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("s1_out_pc", out_pc, 64'h0000_0000_8000_0000);
    chk("s1_out_instr", {32'd0, out_instr}, 64'h0050_0093);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s2_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("s2_hold_instr", {32'd0, out_instr}, 64'h0050_0093);
      chk("s2_hold_pc", out_pc, 64'h0000_0000_8000_0000);
      chk("s2_no_req", {63'd0, imem_req_valid}, 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("s2_out_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("s2_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("s2_next_addr", imem_addr, 64'h0000_0000_8000_0004);

    // Scenario 3: redirect while waiting; the next response is dropped.
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0102;
    tick();
    redirect_valid = 1'b0;
    chk("s3_wait_req_valid", {63'd0, imem_req_valid}, 64'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("s3_out_valid", {63'd0, out_valid}, 64'd0);
    chk("s3_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("s3_addr", imem_addr, 64'h0000_0000_8000_0100);

    // Scenario 4: redirect coincident with the response.
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_F00D;
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0200;
    tick();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    chk("s4_out_valid", {63'd0, out_valid}, 64'd0);
    chk("s4_addr", imem_addr, 64'h0000_0000_8000_0200);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0;
    chk("s4_drop_clear_valid", {63'd0, out_valid}, 64'd1);
    chk("s4_drop_clear_pc", out_pc, 64'h0000_0000_8000_0200);
    chk("s4_drop_clear_instr", {32'd0, out_instr}, 64'h1234_5678);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("s4_next_addr", imem_addr, 64'h0000_0000_8000_0204);

    // Redirect in S_REQ without ready, with unaligned target; stray response ignored.
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    imem_rsp_valid = 1'b1;
    tick();
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    chk("rq_redir_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("rq_redir_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("rq_rsp_ignored", {63'd0, out_valid}, 64'd0);

    // Scenario 5: fetch at the top of the address space wraps to zero.
    imem_req_ready = 1'b1;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAABB_CCDD;
    tick();
    imem_rsp_valid = 1'b0;
    chk("s5_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("s5_out_instr", {32'd0, out_instr}, 64'hAABB_CCDD);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("s5_wrap_addr", imem_addr, 64'h0);

    // Redirect in the same cycle the request is accepted.
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0300; settle();
    chk("acc_redir_old_addr", imem_addr, 64'h0);
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    tick();
    imem_rsp_valid = 1'b0;
    chk("acc_redir_dropped", {63'd0, out_valid}, 64'd0);
    chk("acc_redir_addr", imem_addr, 64'h0000_0000_8000_0300);

    // Redirect while holding a valid instruction.
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2222_2222;
    tick();
    imem_rsp_valid = 1'b0;
    chk("sv_out_pc", out_pc, 64'h0000_0000_8000_0300);
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0400;
    tick();
    redirect_valid = 1'b0;
    chk("sv_redir_out_valid", {63'd0, out_valid}, 64'd0);
    chk("sv_redir_addr", imem_addr, 64'h0000_0000_8000_0400);

    // Scenario 6: reset during S_WAIT, response in the first post-reset cycle.
    tick();
    rst = 1'b1; imem_req_ready = 1'b0;
    tick();
    chk("s6_rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("s6_rst_out_instr", {32'd0, out_instr}, 64'h13);
    rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h3333_3333; settle();
    chk("s6_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("s6_addr", imem_addr, 64'h0000_0000_8000_0000);
    tick();
    imem_rsp_valid = 1'b0;
    chk("s6_rsp_ignored", {63'd0, out_valid}, 64'd0);
    chk("s6_addr_hold", imem_addr, 64'h0000_0000_8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
